// File: rtl/char_buf_pkg.sv
// Shared constants and FSM state type for the character buffer loader.
package char_buf_pkg;

  localparam int CHAR_BUF_BASE  = 1500;
  localparam int CHAR_BUF_DEPTH = 108;
  localparam int CHAR_W         = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    BLOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/char_buffer_loader_if.sv
// Character stream, processor store port and RAM write port of the loader.
// in_valid/in_ready: a character transfers on every rising edge where both are
// high; in_valid may not depend on in_ready, and in_data is held while in_valid
// waits for ready.
interface char_buffer_loader_if #(
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [CHAR_W-1:0] in_data;
  logic              in_ready;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output in_valid, in_data, cpu_wren, cpu_addr, cpu_data,
    input  in_ready, mem_wren, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_data, cpu_wren, cpu_addr, cpu_data,
    output in_ready, mem_wren, mem_addr, mem_data
  );
endinterface

// File: rtl/char_fifo.sv
// Small synchronous FIFO (power-of-two depth) buffering incoming characters;
// clear flushes it on the next edge.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("char_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0] store [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = store[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/char_buffer_loader.sv
// Streams characters into a fixed RAM window, yielding the write port to CPU stores.
// Define CHAR_BUFFER_WRAP_EN to make the window a ring instead of stopping when full.
module char_buffer_loader
  import char_buf_pkg::*;
#(
  parameter int BASE_ADDR  = CHAR_BUF_BASE,
  parameter int DEPTH      = CHAR_BUF_DEPTH,
  parameter int CHAR_W     = char_buf_pkg::CHAR_W,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  char_buffer_loader_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  output state_t                       state
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
`ifdef CHAR_BUFFER_WRAP_EN
  localparam bit WRAP_MODE = 1'b1;
`else
  localparam bit WRAP_MODE = 1'b0;
`endif

  if (BASE_ADDR + DEPTH > (1 << ADDR_W)) begin : g_addr_check
    $error("char_buffer_loader: window BASE_ADDR+DEPTH exceeds the RAM address space");
  end

  logic              ready_en;
  logic [CNT_W-1:0]  wptr;
  logic [CHAR_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  level_next;
  logic [CNT_W-1:0]  count_next;
  logic              blocked;
  logic              accept;
  logic              drain;

  char_fifo #(.DEPTH(FIFO_DEPTH), .W(CHAR_W)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (accept),
    .push_data (bus.in_data),
    .pop       (drain),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign full         = (count == DEPTH_C);
  assign blocked      = full && !WRAP_MODE;
  // ready_en holds in_ready low until the first edge after reset release.
  assign bus.in_ready = ready_en && !fifo_full && !clear && !blocked;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = !fifo_empty && !bus.cpu_wren && !clear && (WRAP_MODE || !full);
  assign level_next   = fifo_level + LVL_W'(accept) - LVL_W'(drain);
  assign count_next   = (drain && !full) ? count + 1'b1 : count;

  // Processor stores always own the RAM port; the loader only fills idle cycles.
  always_comb begin
    bus.mem_wren = bus.cpu_wren;
    bus.mem_addr = bus.cpu_addr;
    bus.mem_data = bus.cpu_data;
    if (drain) begin
      bus.mem_wren = 1'b1;
      bus.mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wptr);
      bus.mem_data = DATA_W'(fifo_head);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= EMPTY;
    end else begin
      ready_en <= 1'b1;
      if (clear) begin
        wptr     <= '0;
        count    <= '0;
        overflow <= 1'b0;
        state    <= EMPTY;
      end else begin
        if (drain) begin
          wptr  <= (WRAP_MODE && wptr == LAST_C) ? '0 : wptr + 1'b1;
          count <= count_next;
        end
        if (bus.in_valid && blocked) overflow <= 1'b1;
        case (state)
          BLOCKED: state <= BLOCKED;
          default: begin
            if (!WRAP_MODE && count_next == DEPTH_C) state <= BLOCKED;
            else if (level_next != '0)               state <= LOADING;
            else                                     state <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_buffer_loader.sv
// Bench for char_buffer_loader: directed steps plus a random phase against a
// queue-based model of the loader and an image of the RAM.
module tb_char_buffer_loader;
  import char_buf_pkg::*;

  localparam int BASE = 1500;
  localparam int DEPTH = 108;
  localparam int FD = 4;
  localparam int CW = 8;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef CHAR_BUFFER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  logic clear;
  always #5 clock = ~clock;

  logic [6:0] count;
  logic       full;
  logic       overflow;
  state_t     state;

  char_buffer_loader_if #(.CHAR_W(CW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  char_buffer_loader #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .CHAR_W(CW),
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .state    (state)
  );

  // RAM behind the write port
  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] exp_ram [0:4095];
  always @(posedge clock) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [CW-1:0] exp_q[$];   // characters accepted but not yet written
  int m_count = 0;
  int m_written = 0;         // window writes since the last clear/reset
  bit m_ovf = 0;
  bit m_rst_done = 0;

  always @(negedge clock) begin : monitor
    logic [AW-1:0] ea;
    bit m_full;
    bit e_ready;
    bit e_drain;
    state_t e_state;
    if (!reset_n) begin
      check("rst_in_ready", 32'(bus.in_ready), 32'(0));
      check("rst_count", 32'(count), 32'(0));
      check("rst_overflow", 32'(overflow), 32'(0));
      check("rst_mem_wren", 32'(bus.mem_wren), 32'(bus.cpu_wren));
      check("rst_mem_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
      exp_q.delete();
      m_count = 0;
      m_written = 0;
      m_ovf = 0;
      m_rst_done = 0;
      if (bus.cpu_wren) exp_ram[bus.cpu_addr] = bus.cpu_data;
    end else begin
      m_full  = (m_count == DEPTH);
      e_ready = m_rst_done && (exp_q.size() < FD) && !clear && !(m_full && !WRAP);
      e_drain = (exp_q.size() != 0) && !bus.cpu_wren && !clear && (WRAP || m_written < DEPTH);
      if (!WRAP && m_full)        e_state = BLOCKED;
      else if (exp_q.size() == 0) e_state = EMPTY;
      else                        e_state = LOADING;
      check("in_ready", 32'(bus.in_ready), 32'(e_ready));
      check("count", 32'(count), 32'(m_count));
      check("full", 32'(full), 32'(m_full));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("state", 32'(state), 32'(e_state));
      ea = AW'(BASE + (m_written % DEPTH));
      if (e_drain) begin
        check("drain_wren", 32'(bus.mem_wren), 32'(1));
        check("drain_addr", 32'(bus.mem_addr), 32'(ea));
        check("drain_data", bus.mem_data, DW'(exp_q[0]));
      end else begin
        check("pass_wren", 32'(bus.mem_wren), 32'(bus.cpu_wren));
        if (bus.cpu_wren) begin
          check("pass_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
          check("pass_data", bus.mem_data, bus.cpu_data);
        end
      end
      // advance the model to the state after the coming rising edge
      if (bus.cpu_wren) exp_ram[bus.cpu_addr] = bus.cpu_data;
      if (clear) begin
        exp_q.delete();
        m_count = 0;
        m_written = 0;
        m_ovf = 0;
      end else begin
        if (bus.in_valid && m_full && !WRAP) m_ovf = 1;
        if (e_drain) begin
          exp_ram[ea] = DW'(exp_q.pop_front());
          m_written++;
          if (m_count < DEPTH) m_count++;
        end
        if (bus.in_valid && e_ready) exp_q.push_back(bus.in_data);
      end
      m_rst_done = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic push_char(input logic [CW-1:0] c);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready) done = 1;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL push_timeout observed=not_accepted expected=accepted char=0x%0h", c);
    end
  endtask

  logic [CW-1:0] sent [0:127];

  task automatic feed(input int n, input int max_cycles, output int acc);
    acc = 0;
    for (int i = 0; i < max_cycles && acc < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = sent[acc];
      @(negedge clock);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    int acc;
    int mism;
    for (int a = 0; a < 4096; a++) begin
      ram[a] = '0;
      exp_ram[a] = '0;
    end
    reset_n = 1'b0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.cpu_wren = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;

    // reset values, then in_ready rises only after the first edge past release
    idle(3);
    check("reset_count", 32'(count), 32'(0));
    check("reset_full", 32'(full), 32'(0));
    check("reset_state", 32'(state), 32'(EMPTY));
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_before_edge", 32'(bus.in_ready), 32'(0));
    tick();
    check("ready_after_edge", 32'(bus.in_ready), 32'(1));

    // "A", "B", "C" back to back
    push_char(8'h41);
    push_char(8'h42);
    push_char(8'h43);
    idle(3);
    check("abc_count", 32'(count), 32'(3));
    check("ram_1500_A", ram[1500], 32'h41);
    check("ram_1501_B", ram[1501], 32'h42);
    check("ram_1502_C", ram[1502], 32'h43);

    // CPU store priority
    do_clear();
    bus.cpu_wren = 1'b1;
    bus.cpu_addr = 12'd100;
    bus.cpu_data = 32'd7;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    idle(2);
    bus.cpu_wren = 1'b0;
    idle(3);
    check("cpu_ram_100", ram[100], 32'd7);
    check("ram_1500_55", ram[1500], 32'h55);

    // FIFO fills while the CPU holds the port
    do_clear();
    bus.cpu_wren = 1'b1;
    bus.cpu_addr = 12'd200;
    bus.cpu_data = 32'd9;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = CW'(8'h60 + acc);
      @(negedge clock);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("stall_accepts", 32'(acc), 32'(FD));
    bus.cpu_wren = 1'b0;
    idle(6);
    check("stall_count", 32'(count), 32'(4));
    push_char(8'h64);
    push_char(8'h65);
    idle(3);
    check("stall_ram_1500", ram[1500], 32'h60);
    check("stall_ram_1503", ram[1503], 32'h63);
    check("stall_ram_1505", ram[1505], 32'h65);
    check("stall_count6", 32'(count), 32'(6));

    // 110 characters into the 108-entry window
    do_clear();
    for (int i = 0; i < 128; i++) sent[i] = CW'($urandom_range(1, 255));
    feed(110, 160, acc);
    check("win_accepts", 32'(acc), WRAP ? 32'(110) : 32'(DEPTH + 1));
    idle(3);
    @(negedge clock);
    check("win_count", 32'(count), 32'(DEPTH));
    check("win_full", 32'(full), 32'(1));
    check("win_ready", 32'(bus.in_ready), WRAP ? 32'(1) : 32'(0));
    check("win_overflow", 32'(overflow), WRAP ? 32'(0) : 32'(1));
    tick();
    check("win_ram_1500", ram[1500], DW'(WRAP ? sent[108] : sent[0]));
    check("win_ram_1501", ram[1501], DW'(WRAP ? sent[109] : sent[1]));
    check("win_ram_1502", ram[1502], DW'(sent[2]));
    check("win_ram_1607", ram[1607], DW'(sent[107]));
    check("win_ram_1608", ram[1608], 32'(0));

    // random traffic with interleaved CPU stores
    do_clear();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = CW'($urandom);
      bus.cpu_wren = ($urandom_range(0, 3) == 0);
      bus.cpu_addr = AW'($urandom_range(0, 1499));
      bus.cpu_data = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.cpu_wren = 1'b0;
    idle(10);

    // asynchronous reset in the middle of a burst
    do_clear();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = CW'(8'h31 + i);
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'(0));
    check("async_ready", 32'(bus.in_ready), 32'(0));
    check("async_state", 32'(state), 32'(EMPTY));
    check("async_mem_wren", 32'(bus.mem_wren), 32'(bus.cpu_wren));
    bus.in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    idle(2);

    // clear wins over a pending drain
    bus.cpu_wren = 1'b1;
    bus.cpu_addr = 12'd300;
    bus.cpu_data = 32'hABC;
    push_char(8'h99);
    bus.cpu_wren = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    check("clear_no_write", 32'(bus.mem_wren), 32'(0));
    tick();
    clear = 1'b0;
    idle(2);
    check("clear_count", 32'(count), 32'(0));
    push_char(8'h7E);
    idle(3);
    check("after_clear_ram_1500", ram[1500], 32'h7E);
    check("after_clear_count", 32'(count), 32'(1));

    // whole RAM image against the model
    mism = 0;
    for (int a = 0; a < 4096; a++) begin
      if (ram[a] !== exp_ram[a]) mism++;
    end
    check("ram_image_mismatches", 32'(mism), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_buffer_loader.md
# char_buffer_loader

Parametrised loader that accepts a stream of external characters through a valid/ready handshake and writes each one, zero-extended, into a fixed window of processor data memory. It sits between the external character source, the processor's data-memory write port and the RAM. A small input FIFO absorbs bursts, and the processor's own writes always take priority. Occupancy and overflow status are exported for software polling and the testbench.

## Interface
- BASE_ADDR, 1500, first RAM word of the character window
- DEPTH, 108, window size in characters (12 × 9 grid)
- CHAR_W, 8, character width
- ADDR_W, 12, RAM address width
- DATA_W, 32, RAM data width
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties the FIFO and zeroes the pointer, count and flags
- in_valid  in  1  character available
- in_data  in  CHAR_W  character
- in_ready  out  1  loader can accept
- cpu_wren  in  1  processor store enable
- cpu_addr  in  ADDR_W  processor store address
- cpu_data  in  DATA_W  processor store data
- mem_wren  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_data  out  DATA_W  RAM write data
- count  out  $clog2(DEPTH+1)  characters written to the window, saturating at DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky: in_valid seen while blocked because the window is full

## Operation
- Accept occurs when in_valid && in_ready; in_data is pushed into the FIFO.
- in_ready = !fifo_full && !clear && !(full && !wrap_mode).
- Drain occurs when the FIFO is non-empty and cpu_wren == 0:
  - mem_wren = 1
  - mem_addr = BASE_ADDR + wptr
  - mem_data = {zeros, FIFO head}
  - On the edge: pop, wptr++, count++ (saturating).
- When cpu_wren == 1, the CPU signals pass straight through to the RAM port and the drain stalls. The loader never overrides a processor store.
- Simultaneous accept and drain: FIFO occupancy is unchanged. Order is strictly FIFO.
- Window full without wrap:
  - in_ready = 0.
  - FIFO contents already accepted still drain only while count < DEPTH; after that they are held.
  - overflow is set on any cycle with in_valid && full.
- Address arithmetic: BASE_ADDR + wptr in ADDR_W bits. Elaboration must ensure BASE_ADDR + DEPTH ≤ 2^ADDR_W; an error is raised otherwise.
- clear wins over accept and drain in the same cycle. mem_wren reflects cpu_wren only during clear.
- Internal states: EMPTY (FIFO empty), LOADING (FIFO non-empty, window not full), BLOCKED (window full, no wrap).
  - EMPTY→LOADING on accept.
  - LOADING→EMPTY on the last pop.
  - LOADING/EMPTY→BLOCKED when count reaches DEPTH.
  - BLOCKED→EMPTY only on clear or reset.

## Timing
- Reset (async assert, sync release):
  - FIFO empty
  - wptr = 0, count = 0, full = 0, overflow = 0
  - in_ready = 0 while reset_n is low; 1 from the first edge after release
  - mem_* outputs follow the CPU inputs
- Latency: a character accepted at edge N is written by RAM at edge N+1 at the earliest.
- Write-port outputs are combinational from registered FIFO state and the CPU inputs. There is no combinational path from in_valid to mem_*.
- count and full update on the edge that performs the drain write.
- Throughput: one character per cycle sustained while cpu_wren stays low.

## Configuration
- CHAR_BUFFER_WRAP_EN defined:
  - After entry DEPTH-1, wptr wraps to 0 and the window behaves as a ring.
  - count stays at DEPTH and full stays 1.
  - in_ready ignores full, and overflow never sets.
- Undefined: stop-when-full behaviour as above. wrap_mode is a constant 0.

## Structure
- Package char_buf_pkg holds:
  - default constants CHAR_BUF_BASE = 1500, CHAR_BUF_DEPTH = 108, CHAR_W = 8
  - the state enum {EMPTY, LOADING, BLOCKED}
- One sub-module, char_fifo: synchronous FIFO of FIFO_DEPTH × CHAR_W with push/pop/full/empty and async active-low reset.
- Arbitration, pointer and status logic live in char_buffer_loader.

## Test plan
- Reset, then push "A", "B", "C" (0x41, 0x42, 0x43) on consecutive cycles with cpu_wren = 0 → RAM[1500..1502] = 0x41/0x42/0x43 at edges N+1..N+3; count = 3.
- Push 0x55 while cpu_wren = 1 to address 100 with data 7 for 3 cycles → RAM[100] = 7; 0x55 lands at RAM[1500] on the first cycle with cpu_wren = 0.
- Hold cpu_wren = 1 and push 6 characters with FIFO_DEPTH = 4 → in_ready drops after 4 accepts; no loss; all 4 drain once cpu_wren = 0.
- Push 110 characters, wrap undefined → RAM[1500..1607] written; full = 1; in_ready = 0; overflow = 1; RAM[1608] untouched.
- Same 110 characters with CHAR_BUFFER_WRAP_EN → characters 109–110 overwrite RAM[1500..1501]; overflow = 0; count = 108.
- Assert reset_n low mid-burst, then clear during a drain → outputs reach reset values asynchronously; no RAM write in the clear cycle; the next character goes to RAM[1500].
